// File: rtl/freq_div_by5_core.sv
// ---------------------------------------------------------------------------
// freq_div_by5_core
//
// Divides the incoming clock by a fixed ratio of 5 and produces an output with
// a 50% duty cycle. An odd ratio cannot be split evenly on rising edges alone,
// so the output is built from two flops:
//   - pos_q, a rising-edge flop that is high for 2 input periods (cnt = 1, 2)
//   - neg_q, a falling-edge copy of pos_q, delayed by half an input period
// Their OR is high for 2.5 periods and low for the remaining 2.5.
//
// Ports
//   clk      in   single system clock; both edges are used
//   reset    in   asynchronous active-low reset; assertion acts at once,
//                 release is synchronised to the rising edge of clk
//   clk_by5  out  clk / 5, 50% duty, glitch-free (OR of two flop outputs)
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module freq_div_by5_core (
    input  logic clk,
    input  logic reset,
    output logic clk_by5
);

    // Two-stage release synchroniser. Both stages clear asynchronously while
    // reset is low; a one walks in from the LSB once reset is released.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       run_en;

    // Divider state.
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       pos_q;
    logic       pos_d;
    logic       neg_q;
    logic       neg_d;

    assign run_en = rst_sync_q[1];

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // The counter is held at 0 until the synchroniser releases. Any value of
    // 4 or above (including the unreachable 5-7) returns to 0, so a corrupted
    // count recovers on the very next rising edge.
    always_comb begin
        cnt_d = 3'd0;
        if (run_en && (cnt_q < 3'd4)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // pos_q is decoded from the next count so that it is set on the same edge
    // where cnt becomes 1 and cleared on the edge where cnt becomes 3.
    always_comb begin
        pos_d = (cnt_d == 3'd1) || (cnt_d == 3'd2);
        neg_d = pos_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
            cnt_q      <= 3'd0;
            pos_q      <= 1'b0;
        end else begin
            rst_sync_q <= rst_sync_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
        end
    end

    // Half-period delayed copy of pos_q; it extends the high phase by the
    // duration of the final input high phase.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk_by5 = pos_q | neg_q;

endmodule

// File: tb/tb_freq_div_by5_core.sv
// ---------------------------------------------------------------------------
// tb_freq_div_by5_core
//
// Self-checking bench for freq_div_by5_core. The reference model describes
// the output purely as a waveform: after the first output rising edge, the
// output is high for the next 5 clock half-periods and low for the 5 after
// that, repeating. Measured edge times are compared with 5 input periods
// (period), 2 periods plus one high phase (high time) and 2 periods plus one
// low phase (low time). Reset hold lengths and reset/release instants are
// randomised.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_freq_div_by5_core;

    logic    clk;
    logic    reset;
    logic    clk_by5;

    realtime t_hi = 10.0;
    realtime t_lo = 10.0;

    int      total = 0;
    int      bad   = 0;

    realtime rise_t      = 0.0;
    realtime prev_rise_t = 0.0;
    realtime fall_t      = 0.0;
    logic    clk_at_rise = 1'b0;
    logic    clk_at_fall = 1'b1;

    freq_div_by5_core dut (
        .clk     (clk),
        .reset   (reset),
        .clk_by5 (clk_by5)
    );

    // Clock with independently adjustable low and high phases.
    initial begin
        clk = 1'b0;
        forever begin
            #(t_lo) clk = 1'b1;
            #(t_hi) clk = 1'b0;
        end
    end

    // Timestamp every output edge and note which clock level it came with.
    always @(posedge clk_by5) begin
        prev_rise_t = rise_t;
        rise_t      = $realtime;
        clk_at_rise = clk;
    end

    always @(negedge clk_by5) begin
        fall_t      = $realtime;
        clk_at_fall = clk;
    end

    function automatic int tenths(realtime t);
        return $rtoi(t * 10.0 + 0.5);
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive reset low and check that everything is cleared at once and stays
    // cleared on both edges for the requested number of clock periods.
    task automatic hold_reset(int cycles);
        reset = 1'b0;
        #1;
        checkOutput("reset_immediate_out", clk_by5, 0);
        checkOutput("reset_immediate_cnt", dut.cnt_q, 0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold_out_pos", clk_by5, 0);
            checkOutput("reset_hold_cnt", dut.cnt_q, 0);
            @(negedge clk);
            #1;
            checkOutput("reset_hold_out_neg", clk_by5, 0);
        end
    endtask

    // Release reset at a random point of a low phase and wait for the first
    // output rising edge, which may come up to 2 extra cycles late because of
    // the release synchroniser. Returns just after that rising clock edge.
    task automatic applyStimulus();
        int found;
        int edges;
        found = 0;
        edges = 0;
        @(negedge clk);
        #($urandom_range(1, 5));
        reset = 1'b1;
        for (int i = 1; (i <= 6) && (found == 0); i++) begin
            @(posedge clk);
            #1;
            edges = i;
            if (clk_by5 === 1'b1) begin
                found = 1;
            end
        end
        checkOutput("first_rise_found", found, 1);
        checkOutput("first_rise_latency", ((edges >= 1) && (edges <= 3)) ? 1 : 0, 1);
        checkOutput("first_rise_on_clk_rise", clk_at_rise, 1);
        checkOutput("first_cnt", dut.cnt_q, 1);
    endtask

    // Walk n_half clock edges from an output rising edge, checking the
    // waveform, the count and the measured edge timing.
    task automatic run_model(int n_half);
        int period_t;
        int exp_out;
        period_t = tenths(t_hi + t_lo);
        for (int h = 1; h <= n_half; h++) begin
            @(clk);
            #1;
            exp_out = ((h % 10) < 5) ? 1 : 0;
            checkOutput("clk_by5_wave", clk_by5, exp_out);
            if ((h % 2) == 0) begin
                checkOutput("cnt_seq", dut.cnt_q, ((h / 2) + 1) % 5);
                checkOutput("cnt_legal", (dut.cnt_q <= 3'd4) ? 1 : 0, 1);
            end
            if ((h % 10) == 5) begin
                checkOutput("high_time", tenths(fall_t - rise_t), 2 * period_t + tenths(t_hi));
                checkOutput("fall_on_clk_fall", clk_at_fall, 0);
            end
            if ((h % 10) == 0) begin
                checkOutput("period", tenths(rise_t - prev_rise_t), 5 * period_t);
                checkOutput("low_time", tenths(rise_t - fall_t), 2 * period_t + tenths(t_lo));
                checkOutput("rise_on_clk_rise", clk_at_rise, 1);
            end
        end
    endtask

    // Wait a random time into the current high output phase, then reset.
    task automatic reset_while_high(int max_delay);
        checkOutput("out_high_before_reset", clk_by5, 1);
        #($urandom_range(1, max_delay));
        hold_reset($urandom_range(1, 3));
    endtask

    initial begin
        reset = 1'b0;
        #1;
        checkOutput("reset_no_edge_out", clk_by5, 0);
        checkOutput("reset_no_edge_cnt", dut.cnt_q, 0);
        hold_reset(3);

        $display("[TB] 20 ns clock, 50%% duty");
        applyStimulus();
        run_model(40);
        run_model(500);

        for (int k = 0; k < 3; k++) begin
            reset_while_high(6);
            applyStimulus();
            run_model(30);
        end

        $display("[TB] 30 ns clock, 45/55 duty");
        reset_while_high(6);
        t_hi = 13.5;
        t_lo = 16.5;
        hold_reset(2);
        applyStimulus();
        run_model(60);
        reset_while_high(9);
        applyStimulus();
        run_model(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
